kmeans_apb_sequencer: RTL

//  APB master that runs one complete Kmeans job on the Kmeans APB slave.
//  - Accepts a job command and streams in initial centroids and points.
//  - Writes them to the slave's centroid registers and point RAM, then writes CTRL to start the run.
//  - Waits for the slave interupt, reads the result centroids back and streams them out.
//  - Sits between the host/DMA stream logic and the Kmeans APB slave port.

---
 rtl/kmeans_apb_sequencer_if.sv | 29 ++
 rtl/kmeans_apb_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_apb_sequencer_if.sv
// APB bus between the Kmeans job sequencer (master) and the Kmeans slave.
// Signals:
//   psel, penable, pwrite  transfer control, driven by the master
//   paddr                  transfer address, driven by the master
//   pwdata                 write data, driven by the master
//   prdata                 read data, driven by the slave
//   pready                 access-phase completion, driven by the slave
interface kmeans_apb_sequencer_if #(
  parameter int addrWidth = 9,
  parameter int dataWidth = 91
);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [addrWidth-1:0] paddr;
  logic [dataWidth-1:0] pwdata;
  logic [dataWidth-1:0] prdata;
  logic                 pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/kmeans_apb_sequencer.sv
// APB master that runs one complete Kmeans job on the Kmeans APB slave:
// loads the initial centroids and the points from the input stream, starts
// the slave through CTRL, waits for its interupt and streams the result
// centroids back out.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, num_points    job request (taken only in IDLE) and its point count
//   in_valid/ready/data  input stream: centroid_num centroid words, then points
//   out_valid/ready/data result centroid stream
//   busy, done, err      job status (done is a one-cycle pulse, err is sticky)
//   apb                  APB master port
//   interupt             slave job-complete level
module kmeans_apb_sequencer #(
  parameter int addrWidth         = 9,
  parameter int dataWidth         = 91,
  parameter int centroid_num      = 8,
  parameter int log2_of_point_cnt = 9,
  parameter int RAM_BASE          = 16,
  parameter int MAX_POINTS        = 496,
  parameter int TIMEOUT_CYCLES    = 1 << 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [log2_of_point_cnt-1:0] num_points,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [dataWidth-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [dataWidth-1:0]         out_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  kmeans_apb_sequencer_if.master       apb,
  input  logic                         interupt
);

  localparam int CW = $clog2(centroid_num) + 1;
  localparam int PW = log2_of_point_cnt;
  localparam logic [CW-1:0]        LAST_CENT = CW'(centroid_num - 1);
  localparam logic [PW-1:0]        MAX_PTS   = PW'(MAX_POINTS);
  localparam logic [addrWidth-1:0] BASE      = addrWidth'(RAM_BASE);
  localparam logic [20:0]          TO_LAST   = 21'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, CHECK, LOAD_CENT, LOAD_PTS, KICK, WAIT_IRQ, READ_CENT, PUSH, FINISH
  } state_t;

  state_t               state;
  logic                 psel_reg, penable_reg, pwrite_reg;
  logic [addrWidth-1:0] paddr_reg;
  logic [dataWidth-1:0] pwdata_reg;
  logic [PW-1:0]        npts;
  logic [PW-1:0]        pt_idx;
  logic [CW-1:0]        cent_idx;
  logic [20:0]          wait_cnt;
  logic [addrWidth-1:0] cent_addr, pt_addr;

  assign apb.psel    = psel_reg;
  assign apb.penable = penable_reg;
  assign apb.pwrite  = pwrite_reg;
  assign apb.paddr   = paddr_reg;
  assign apb.pwdata  = pwdata_reg;

  // Centroid registers live at 1..centroid_num, points at RAM_BASE+i.
  assign cent_addr = addrWidth'(cent_idx + CW'(1));
  assign pt_addr   = BASE + addrWidth'(pt_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      npts        <= '0;
      pt_idx      <= '0;
      cent_idx    <= '0;
      wait_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (psel_reg && !penable_reg) begin
        // SETUP always lasts exactly one cycle.
        penable_reg <= 1'b1;
      end else if (psel_reg) begin
        // ACCESS: everything holds until the slave completes the transfer.
        if (apb.pready) begin
          psel_reg    <= 1'b0;
          penable_reg <= 1'b0;
          case (state)
            LOAD_CENT: begin
              in_ready <= 1'b1;
              if (cent_idx == LAST_CENT) begin
                cent_idx <= '0;
                state    <= LOAD_PTS;
              end else begin
                cent_idx <= cent_idx + CW'(1);
              end
            end
            LOAD_PTS: begin
              if (pt_idx == npts - PW'(1)) begin
                state <= KICK;
              end else begin
                pt_idx   <= pt_idx + PW'(1);
                in_ready <= 1'b1;
              end
            end
            KICK: begin
              wait_cnt <= '0;
              state    <= WAIT_IRQ;
            end
            READ_CENT: begin
              out_data  <= apb.prdata;
              out_valid <= 1'b1;
              state     <= PUSH;
            end
            default: ;
          endcase
        end
      end else begin
        // Bus idle: this is the only place a new transfer may begin, which
        // guarantees at least one psel-low cycle between transfers.
        case (state)
          IDLE: begin
            if (start) begin
              npts     <= num_points;
              err      <= 1'b0;
              busy     <= 1'b1;
              pt_idx   <= '0;
              cent_idx <= '0;
              state    <= CHECK;
            end
          end
          CHECK: begin
            if (npts == '0 || npts > MAX_PTS) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              in_ready <= 1'b1;
              state    <= LOAD_CENT;
            end
          end
          LOAD_CENT, LOAD_PTS: begin
            if (in_valid && in_ready) begin
              psel_reg   <= 1'b1;
              pwrite_reg <= 1'b1;
              pwdata_reg <= in_data;
              paddr_reg  <= (state == LOAD_CENT) ? cent_addr : pt_addr;
              in_ready   <= 1'b0;
            end
          end
          KICK: begin
            psel_reg   <= 1'b1;
            pwrite_reg <= 1'b1;
            paddr_reg  <= '0;
            pwdata_reg <= {{(dataWidth - PW - 1){1'b0}}, npts, 1'b1};
          end
          WAIT_IRQ: begin
            // interupt is tested first so it wins over a same-cycle timeout.
            if (interupt) begin
              cent_idx <= '0;
              state    <= READ_CENT;
            end else if (wait_cnt == TO_LAST) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              wait_cnt <= wait_cnt + 21'd1;
            end
          end
          READ_CENT: begin
            psel_reg   <= 1'b1;
            pwrite_reg <= 1'b0;
            paddr_reg  <= cent_addr;
          end
          PUSH: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (cent_idx == LAST_CENT) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                cent_idx <= cent_idx + CW'(1);
                state    <= READ_CENT;
              end
            end
          end
          FINISH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
